// File: rtl/morra_match_ctrl_if.sv
// Player move handshakes and game-core round bus for the morra match controller.
// master: controller side (drives readies, core_strobe, captured moves).
// slave:  environment side (players offer moves, core reports round/match verdicts).
interface morra_match_ctrl_if;
  logic [1:0] g1_move;
  logic       g1_valid;
  logic       g1_ready;
  logic [1:0] g2_move;
  logic       g2_valid;
  logic       g2_ready;
  logic       core_strobe;
  logic [1:0] core_g1;
  logic [1:0] core_g2;
  logic       core_done;
  logic [1:0] core_manche;
  logic [1:0] core_partita;

  modport master (
    input  g1_move, g1_valid, g2_move, g2_valid,
    input  core_done, core_manche, core_partita,
    output g1_ready, g2_ready, core_strobe, core_g1, core_g2
  );

  modport slave (
    output g1_move, g1_valid, g2_move, g2_valid,
    output core_done, core_manche, core_partita,
    input  g1_ready, g2_ready, core_strobe, core_g1, core_g2
  );
endinterface

// File: rtl/morra_match_ctrl.sv
// Morra match controller: collects a move per player, issues rounds to the game core, tracks the match.
// Latency: move captured on the handshake edge; core_strobe the cycle after the pair completes.
// Backpressure: gN_ready drops once player N's move is captured; core result awaited indefinitely in WAIT_CORE.
// Ports: clk, reset (sync, active-low), start/cfg_extra/ack (host control),
//        busy/match_done/match_result/round_count/err_g1/err_g2 (status), bus (players + core, master side).
module morra_match_ctrl #(
  parameter int TIMEOUT = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            cfg_extra,
  input  logic                  ack,
  output logic                  busy,
  output logic                  match_done,
  output logic [1:0]            match_result,
  output logic [4:0]            round_count,
  output logic                  err_g1,
  output logic                  err_g2,
  morra_match_ctrl_if.master    bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] COLLECT   = 3'd1;
  localparam logic [2:0] ISSUE     = 3'd2;
  localparam logic [2:0] WAIT_CORE = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam logic [7:0] TMO_LIMIT = TIMEOUT[7:0];

  logic [2:0] state;
  logic [4:0] max_rounds;
  logic [4:0] rnd_q;
  logic [1:0] blk1, blk2;
  logic [1:0] cap_g1, cap_g2;
  logic       got1, got2;
  logic [7:0] tmo_cnt;
  logic [1:0] result_q;
  logic       err1_q, err2_q;

  logic       in_collect;
  logic       hs1, hs2;
  logic       legal1, legal2;
  logic       take1, take2;
  logic       got1_nxt, got2_nxt;
  logic [7:0] tmo_nxt;
  logic [4:0] rnd_nxt;

  assign in_collect = (state == COLLECT);
  assign hs1        = in_collect && !got1 && bus.g1_valid;
  assign hs2        = in_collect && !got2 && bus.g2_valid;
  // A player may not repeat the move that just won them a round.
  assign legal1     = (bus.g1_move != 2'b00) && (bus.g1_move != blk1);
  assign legal2     = (bus.g2_move != 2'b00) && (bus.g2_move != blk2);
  assign take1      = hs1 && legal1;
  assign take2      = hs2 && legal2;
  assign got1_nxt   = got1 | take1;
  assign got2_nxt   = got2 | take2;
  assign tmo_nxt    = tmo_cnt + 8'd1;
  // Invalid rounds (manche 00) are replayed and never counted.
  assign rnd_nxt    = ((bus.core_manche != 2'b00) && (rnd_q != 5'd31)) ? rnd_q + 5'd1 : rnd_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      max_rounds <= '0;
      rnd_q      <= '0;
      blk1       <= '0;
      blk2       <= '0;
      cap_g1     <= '0;
      cap_g2     <= '0;
      got1       <= 1'b0;
      got2       <= 1'b0;
      tmo_cnt    <= '0;
      result_q   <= '0;
      err1_q     <= 1'b0;
      err2_q     <= 1'b0;
    end else begin
      err1_q <= hs1 && !legal1;
      err2_q <= hs2 && !legal2;
      case (state)
        IDLE: begin
          if (start) begin
            max_rounds <= 5'd4 + {1'b0, cfg_extra};
            rnd_q      <= '0;
            blk1       <= '0;
            blk2       <= '0;
            result_q   <= '0;
            got1       <= 1'b0;
            got2       <= 1'b0;
            tmo_cnt    <= '0;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          tmo_cnt <= tmo_nxt;
          if (take1) begin
            cap_g1 <= bus.g1_move;
            got1   <= 1'b1;
          end
          if (take2) begin
            cap_g2 <= bus.g2_move;
            got2   <= 1'b1;
          end
          // Completing the pair wins over an expiring timeout in the same cycle.
          if (got1_nxt && got2_nxt) begin
            state <= ISSUE;
          end else if (tmo_nxt == TMO_LIMIT) begin
            // The player who did show up wins; nobody showing up is a draw.
            result_q <= (got1_nxt || got2_nxt) ? {got2_nxt, got1_nxt} : 2'b11;
            state    <= DONE;
          end
        end
        ISSUE: begin
          state <= WAIT_CORE;
        end
        WAIT_CORE: begin
          if (bus.core_done) begin
            case (bus.core_manche)
              2'b01: begin
                blk1 <= cap_g1;
                blk2 <= 2'b00;
              end
              2'b10: begin
                blk2 <= cap_g2;
                blk1 <= 2'b00;
              end
              2'b11: begin
                blk1 <= 2'b00;
                blk2 <= 2'b00;
              end
              default: ;
            endcase
            rnd_q <= rnd_nxt;
            if (bus.core_partita != 2'b00) begin
              result_q <= bus.core_partita;
              state    <= DONE;
            end else if (rnd_nxt == max_rounds) begin
              result_q <= 2'b11;
              state    <= DONE;
            end else begin
              got1    <= 1'b0;
              got2    <= 1'b0;
              tmo_cnt <= '0;
              state   <= COLLECT;
            end
          end
        end
        DONE: begin
          if (ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy            = (state != IDLE) && (state != DONE);
  assign match_done      = (state == DONE);
  assign match_result    = result_q;
  assign round_count     = rnd_q;
  assign err_g1          = err1_q;
  assign err_g2          = err2_q;
  assign bus.g1_ready    = in_collect && !got1;
  assign bus.g2_ready    = in_collect && !got2;
  // Derived from state only, so reset (forcing IDLE) can never leave a stray strobe.
  assign bus.core_strobe = (state == ISSUE);
  assign bus.core_g1     = cap_g1;
  assign bus.core_g2     = cap_g2;

endmodule

// File: tb/tb_morra_match_ctrl.sv
// Directed bench for morra_match_ctrl with TIMEOUT = 5.
module tb_morra_match_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] cfg_extra;
  logic       ack;
  logic       busy, match_done, err_g1, err_g2;
  logic [1:0] match_result;
  logic [4:0] round_count;
  int         n_checks = 0;
  int         n_fail = 0;
  int         strobe_cnt = 0;
  int         s0;

  morra_match_ctrl_if bus ();

  morra_match_ctrl #(.TIMEOUT(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_extra    (cfg_extra),
    .ack          (ack),
    .busy         (busy),
    .match_done   (match_done),
    .match_result (match_result),
    .round_count  (round_count),
    .err_g1       (err_g1),
    .err_g2       (err_g2),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.core_strobe) strobe_cnt <= strobe_cnt + 1;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_reply(input logic [1:0] manche, input logic [1:0] partita);
    bus.core_done    = 1'b1;
    bus.core_manche  = manche;
    bus.core_partita = partita;
    tick();
    bus.core_done    = 1'b0;
    bus.core_manche  = 2'b00;
    bus.core_partita = 2'b00;
  endtask

  // Both players offer legal moves together: ISSUE, then WAIT_CORE.
  task automatic play_pair(input logic [1:0] m1, input logic [1:0] m2);
    bus.g1_move = m1; bus.g1_valid = 1'b1;
    bus.g2_move = m2; bus.g2_valid = 1'b1;
    tick();
    bus.g1_valid = 1'b0; bus.g2_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; cfg_extra = 4'd0; ack = 1'b0;
    bus.g1_move = 2'b00; bus.g1_valid = 1'b0;
    bus.g2_move = 2'b00; bus.g2_valid = 1'b0;
    bus.core_done = 1'b0; bus.core_manche = 2'b00; bus.core_partita = 2'b00;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", match_done, 0);
    check("rst_result", match_result, 0);
    check("rst_rounds", round_count, 0);
    check("rst_g1_ready", bus.g1_ready, 0);
    check("rst_strobe", bus.core_strobe, 0);
    reset = 1'b1;
    tick();

    // Round 1: same-cycle capture, P1 rock beats P2 scissors.
    start = 1'b1; tick(); start = 1'b0;
    check("a_busy", busy, 1);
    check("a_g1_ready", bus.g1_ready, 1);
    check("a_g2_ready", bus.g2_ready, 1);
    bus.g1_move = 2'b01; bus.g1_valid = 1'b1;
    bus.g2_move = 2'b11; bus.g2_valid = 1'b1;
    tick();
    check("a_both_cap_r1", bus.g1_ready, 0);
    check("a_both_cap_r2", bus.g2_ready, 0);
    check("a_issue_strobe", bus.core_strobe, 1);
    check("a_core_g1", bus.core_g1, 2'b01);
    check("a_core_g2", bus.core_g2, 2'b11);
    bus.g1_valid = 1'b0; bus.g2_valid = 1'b0;
    tick();
    check("a_strobe_1cyc", bus.core_strobe, 0);
    core_reply(2'b01, 2'b00);
    check("a_rounds1", round_count, 1);
    check("a_blk1", dut.blk1, 2'b01);
    check("a_back_collect", bus.g1_ready, 1);
    check("a_strobes", strobe_cnt, 1);

    // Round 2: P1 repeats its winning move, is rejected, then plays paper.
    bus.g1_move = 2'b01; bus.g1_valid = 1'b1;
    tick();
    check("b_err_g1", err_g1, 1);
    check("b_g1_ready_held", bus.g1_ready, 1);
    bus.g1_move = 2'b10;
    tick();
    check("b_err_pulse", err_g1, 0);
    check("b_g1_captured", bus.g1_ready, 0);
    check("b_core_g1", bus.core_g1, 2'b10);
    bus.g1_valid = 1'b0;
    bus.g2_move = 2'b10; bus.g2_valid = 1'b1;
    tick();
    bus.g2_valid = 1'b0;
    check("b_issue", bus.core_strobe, 1);
    tick();
    core_reply(2'b10, 2'b01);
    check("b_done", match_done, 1);
    check("b_result", match_result, 2'b01);
    check("b_rounds2", round_count, 2);
    check("b_busy", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("b_start_ignored", match_done, 1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("b_ack_idle", match_done, 0);
    check("b_result_kept", match_result, 2'b01);

    // Timeout: only P2 moves within 5 collect cycles.
    start = 1'b1; tick(); start = 1'b0;
    check("t_result_clr", match_result, 0);
    s0 = strobe_cnt;
    bus.g2_move = 2'b01; bus.g2_valid = 1'b1;
    tick();
    bus.g2_valid = 1'b0;
    tick(); tick(); tick();
    check("t_not_yet", match_done, 0);
    tick();
    check("t_done", match_done, 1);
    check("t_result", match_result, 2'b10);
    check("t_no_strobe", strobe_cnt - s0, 0);
    ack = 1'b1; tick(); ack = 1'b0;

    // Illegal 00 move, an uncounted invalid round, then four ties.
    cfg_extra = 4'd0;
    start = 1'b1; tick(); start = 1'b0;
    bus.g1_move = 2'b01; bus.g1_valid = 1'b1;
    bus.g2_move = 2'b00; bus.g2_valid = 1'b1;
    tick();
    bus.g1_valid = 1'b0;
    check("c_err_g2", err_g2, 1);
    check("c_g2_ready", bus.g2_ready, 1);
    bus.g2_move = 2'b01;
    tick();
    bus.g2_valid = 1'b0;
    tick();
    core_reply(2'b00, 2'b00);
    check("c_invalid_nocount", round_count, 0);
    for (int r = 1; r <= 4; r++) begin
      play_pair(2'b01, 2'b01);
      core_reply(2'b11, 2'b00);
      if (r == 3) begin
        check("c_rounds3", round_count, 3);
        check("c_not_done3", match_done, 0);
      end
    end
    check("c_rounds4", round_count, 4);
    check("c_done", match_done, 1);
    check("c_draw", match_result, 2'b11);
    ack = 1'b1; tick(); ack = 1'b0;
    check("c_idle_busy", busy, 0);
    check("c_idle_done", match_done, 0);

    // Reset during WAIT_CORE, then a late core_done.
    start = 1'b1; tick(); start = 1'b0;
    play_pair(2'b10, 2'b11);
    check("d_in_wait", busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    s0 = strobe_cnt;
    core_reply(2'b01, 2'b01);
    tick(); tick();
    check("d_busy", busy, 0);
    check("d_done", match_done, 0);
    check("d_result", match_result, 0);
    check("d_rounds", round_count, 0);
    check("d_core_g1", bus.core_g1, 0);
    check("d_g1_ready", bus.g1_ready, 0);
    check("d_no_strobe", strobe_cnt - s0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/morra_match_ctrl.md
MORRA_MATCH_CTRL -- requirements
Module: morra_match_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 200, SHALL set the per-round move-collection limit in clock cycles (range 1-255).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 start  in  1  begin a new match; SHALL be sampled in IDLE only.
REQ-005 cfg_extra  in  4  extra rounds; max_rounds = 4 + cfg_extra, 5-bit, latched at start.
REQ-006 g1_move / g2_move  in  2  move (01 rock, 10 paper, 11 scissors; 00 illegal).
REQ-007 g1_valid / g2_valid  in  1  move offered.
REQ-008 g1_ready / g2_ready  out  1  controller accepts move.
REQ-009 core_strobe  out  1  one-cycle round issue to game core.
REQ-010 core_g1 / core_g2  out  2  captured moves, held stable from core_strobe until core_done.
REQ-011 core_done  in  1  core round complete.
REQ-012 core_manche  in  2  round outcome (00 invalid, 01 P1, 10 P2, 11 tie), valid with core_done.
REQ-013 core_partita  in  2  core match verdict (00 running), valid with core_done.
REQ-014 busy  out  1  high in every state except IDLE and DONE.
REQ-015 match_done  out  1  high in DONE.
REQ-016 match_result  out  2  01 P1, 10 P2, 11 draw; held in DONE.
REQ-017 round_count  out  5  counted rounds of the current match.
REQ-018 err_g1 / err_g2  out  1  one-cycle pulse on rejected move.
REQ-019 ack  in  1  host acknowledges result.

Function
REQ-020 FSM states SHALL be IDLE, COLLECT, ISSUE, WAIT_CORE, DONE.
REQ-021 IDLE: on start=1, latch max_rounds, clear round_count, both block registers and match_result, go to COLLECT.
REQ-022 COLLECT: gN_ready = 1 while player N has no captured move; a handshake occurs when gN_valid and gN_ready are both high.
REQ-023 On a handshake, a move that is 00 or equals player N's block register SHALL not be captured; errN SHALL pulse the next cycle and gN_ready SHALL stay high.
REQ-024 Both players SHALL be acceptable in the same cycle; once a player's move is captured, further valid pulses from that player SHALL be ignored until the next round.
REQ-025 The timeout counter SHALL clear on entry to COLLECT and increment each COLLECT cycle.
REQ-026 When the counter reaches TIMEOUT without both moves captured, go to DONE with match_result = 01 if only P1 has a move, 10 if only P2 has a move, 11 if neither has.
REQ-027 A move capture that completes the pair takes priority over timeout expiry in the same cycle.
REQ-028 With both moves captured, go to ISSUE; ISSUE SHALL assert core_strobe for exactly one cycle, then go to WAIT_CORE.
REQ-029 WAIT_CORE: hold until core_done; core_done in any other state SHALL be ignored.
REQ-030 On core_done with manche 01: blk1 = core_g1, blk2 = 00. With manche 10: blk2 = core_g2, blk1 = 00. With manche 11: both blocks = 00. With manche 00: blocks unchanged.
REQ-031 round_count SHALL increment on manche 01/10/11, never on 00, and saturate at 31.
REQ-032 After the REQ-030 update: if core_partita != 00, match_result = core_partita and go to DONE; else if the updated round_count == max_rounds, match_result = 11 and go to DONE; else go to COLLECT with captured flags cleared.
REQ-033 DONE: match_done = 1; start SHALL be ignored; ack = 1 SHALL return to IDLE, with match_result retained until the next start.

Reset
REQ-034 reset = 0 at any clock edge SHALL force IDLE and, in every state, clear all outputs, the block registers, the captured flags, the timeout counter, round_count and max_rounds to 0.
REQ-035 An abandoned round SHALL never raise core_strobe after reset deasserts.

Verification
REQ-036 cfg_extra = 0, P1 rock / P2 scissors, core returns manche 01, partita 00 -> one core_strobe, round_count = 1, blk1 = 01, back to COLLECT.
REQ-037 The next round P1 offers rock -> err_g1 pulse, no capture, g1_ready stays 1; P1 then offers paper -> captured.
REQ-038 Only P2 supplies a move within TIMEOUT = 5 cycles -> DONE, match_result = 10, no core_strobe.
REQ-039 cfg_extra = 0, four tie rounds with partita 00 -> round_count = 4, DONE, match_result = 11; ack -> IDLE.
REQ-040 Both players valid in the same cycle with legal moves -> both captured that cycle, ISSUE next cycle.
REQ-041 reset = 0 asserted during WAIT_CORE, then a late core_done -> IDLE, all outputs 0, core_done ignored.
